// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU.
// One radix-2 shift-add / restoring-divide step per cycle; the result commits to HI/LO.
module ex_muldiv_ctrl #(
    parameter int BITS_SIZE = 32,
    parameter int BITS_CNT  = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [1:0]           i_op,
    input  logic [BITS_SIZE-1:0] i_data_a,
    input  logic [BITS_SIZE-1:0] i_data_b,
    input  logic                 i_flush,
    output logic                 o_stall,
    output logic                 o_done,
    output logic                 o_div_by_zero,
    output logic [BITS_SIZE-1:0] o_hi,
    output logic [BITS_SIZE-1:0] o_lo
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [BITS_CNT-1:0]    CNT_ZERO = {BITS_CNT{1'b0}};
    localparam logic [BITS_CNT-1:0]    CNT_ONE  = {{(BITS_CNT-1){1'b0}}, 1'b1};
    localparam logic [BITS_CNT-1:0]    CNT_LAST = BITS_CNT'(BITS_SIZE - 1);
    localparam logic [BITS_SIZE-1:0]   W_ZERO   = {BITS_SIZE{1'b0}};
    localparam logic [BITS_SIZE-1:0]   W_ONES   = {BITS_SIZE{1'b1}};
    localparam logic [BITS_SIZE:0]     W1_ZERO  = {(BITS_SIZE+1){1'b0}};

    logic [1:0]           state_r;
    logic [BITS_CNT-1:0]  cnt_r;
    logic                 is_div_r;
    logic                 neg_q_r;
    logic                 neg_r_r;
    logic                 dbz_r;
    logic [BITS_SIZE-1:0] opnd_r;
    logic [BITS_SIZE-1:0] raw_a_r;
    logic [BITS_SIZE-1:0] work_hi_r;
    logic [BITS_SIZE-1:0] work_lo_r;
    logic [BITS_SIZE-1:0] hi_r;
    logic [BITS_SIZE-1:0] lo_r;
    logic                 done_r;
    logic                 dbz_out_r;

    logic                 signed_op_s;
    logic                 sign_a_s;
    logic                 sign_b_s;
    logic [BITS_SIZE-1:0] mag_a_s;
    logic [BITS_SIZE-1:0] mag_b_s;
    logic [BITS_SIZE:0]   mul_sum_s;
    logic [BITS_SIZE:0]   div_shift_s;
    logic [BITS_SIZE:0]   div_diff_s;
    logic [BITS_SIZE-1:0] step_hi_s;
    logic [BITS_SIZE-1:0] step_lo_s;
    logic [2*BITS_SIZE-1:0] prod_s;
    logic [2*BITS_SIZE-1:0] mul_res_s;
    logic [BITS_SIZE-1:0] res_hi_s;
    logic [BITS_SIZE-1:0] res_lo_s;

    // Operand decode at issue: magnitudes only for the signed ops.
    always_comb begin
        signed_op_s = ~i_op[0];
        sign_a_s    = signed_op_s & i_data_a[BITS_SIZE-1];
        sign_b_s    = signed_op_s & i_data_b[BITS_SIZE-1];
        if (sign_a_s) begin
            mag_a_s = -i_data_a;
        end else begin
            mag_a_s = i_data_a;
        end
        if (sign_b_s) begin
            mag_b_s = -i_data_b;
        end else begin
            mag_b_s = i_data_b;
        end
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : W1_ZERO);
        div_shift_s = {work_hi_r, work_lo_r[BITS_SIZE-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (!div_diff_s[BITS_SIZE]) begin
                step_hi_s = div_diff_s[BITS_SIZE-1:0];
                step_lo_s = {work_lo_r[BITS_SIZE-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[BITS_SIZE-1:0];
                step_lo_s = {work_lo_r[BITS_SIZE-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[BITS_SIZE:1];
            step_lo_s = {mul_sum_s[0], work_lo_r[BITS_SIZE-1:1]};
        end
    end

    // Final sign fix-up and divide-by-zero override, used on the last iteration.
    always_comb begin
        prod_s = {step_hi_s, step_lo_s};
        if (neg_q_r) begin
            mul_res_s = -prod_s;
        end else begin
            mul_res_s = prod_s;
        end
        if (!is_div_r) begin
            res_hi_s = mul_res_s[2*BITS_SIZE-1:BITS_SIZE];
            res_lo_s = mul_res_s[BITS_SIZE-1:0];
        end else if (dbz_r) begin
            res_hi_s = raw_a_r;
            res_lo_s = W_ONES;
        end else begin
            res_hi_s = neg_r_r ? -step_hi_s : step_hi_s;
            res_lo_s = neg_q_r ? -step_lo_s : step_lo_s;
        end
    end

    // Sequencer: reset beats flush, flush beats start and completion.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            dbz_r     <= 1'b0;
            opnd_r    <= W_ZERO;
            raw_a_r   <= W_ZERO;
            work_hi_r <= W_ZERO;
            work_lo_r <= W_ZERO;
            hi_r      <= W_ZERO;
            lo_r      <= W_ZERO;
            done_r    <= 1'b0;
            dbz_out_r <= 1'b0;
        end else if (i_flush) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            done_r    <= 1'b0;
            dbz_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r    <= 1'b0;
                    dbz_out_r <= 1'b0;
                    if (i_start) begin
                        state_r   <= ST_BUSY;
                        cnt_r     <= CNT_ZERO;
                        is_div_r  <= i_op[1];
                        neg_q_r   <= sign_a_s ^ sign_b_s;
                        neg_r_r   <= sign_a_s;
                        dbz_r     <= (i_data_b == W_ZERO);
                        raw_a_r   <= i_data_a;
                        work_hi_r <= W_ZERO;
                        // Divide shifts the dividend out of LO; multiply shifts the multiplier.
                        work_lo_r <= i_op[1] ? mag_a_s : mag_b_s;
                        opnd_r    <= i_op[1] ? mag_b_s : mag_a_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    work_hi_r <= step_hi_s;
                    work_lo_r <= step_lo_s;
                    if (cnt_r == CNT_LAST) begin
                        state_r   <= ST_DONE;
                        cnt_r     <= CNT_ZERO;
                        hi_r      <= res_hi_s;
                        lo_r      <= res_lo_s;
                        done_r    <= 1'b1;
                        dbz_out_r <= is_div_r & dbz_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    done_r    <= 1'b0;
                    dbz_out_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= CNT_ZERO;
                    done_r    <= 1'b0;
                    dbz_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall       = ((state_r == ST_IDLE) & i_start) | (state_r == ST_BUSY);
    assign o_done        = done_r;
    assign o_div_by_zero = dbz_out_r;
    assign o_hi          = hi_r;
    assign o_lo          = lo_r;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: vector table with scoreboard,
// plus directed flush / back-to-back / reset-mid-operation sequences.
module tb_ex_muldiv_ctrl;

    localparam int W = 32;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;
    logic         flush = 1'b0;
    logic         stall, done, dbz;
    logic [W-1:0] hi, lo;

    ex_muldiv_ctrl #(.BITS_SIZE(W), .BITS_CNT(6)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op),
        .i_data_a(data_a), .i_data_b(data_b), .i_flush(flush),
        .o_stall(stall), .o_done(done), .o_div_by_zero(dbz),
        .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    vec_t   vecs[12];
    exp_t   sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: o_done with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            check({name, " hi"}, hi, e.hi);
            check({name, " lo"}, lo, e.lo);
            check({name, " dbz"}, dbz, e.dbz);
            cur_hi = e.hi;
            cur_lo = e.lo;
        end
    endtask

    // Issue one operation, measure stall/latency, compare against the scoreboard.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input logic ed);
        exp_t e;
        int   n;
        int   stalls;
        bit   seen;
        e.hi = eh; e.lo = el; e.dbz = ed;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; op = o; data_a = a; data_b = b;
        n = 0; stalls = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                stalls += int'(stall);
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
        end
        check({name, " done seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({name, " latency"}, 64'(n), 64'(W + 1));
            check({name, " stall cycles"}, 64'(stalls), 64'(W + 1));
            check({name, " stall in done"}, 64'(stall), 64'd0);
            pop_compare(name);
            @(negedge clk);
            check({name, " done one cycle"}, 64'(done), 64'd0);
            check({name, " dbz one cycle"}, 64'(dbz), 64'd0);
            check({name, " hi held"}, hi, cur_hi);
        end else begin
            void'(sb_q.pop_front());
            start = 1'b0;
        end
    endtask

    // Start a MULT, flush on the edge that would execute BUSY iteration iter.
    task automatic flush_at(input string name, input int iter);
        int ndone;
        @(posedge clk); #1;
        start = 1'b1; op = OP_MULT; data_a = 32'd5; data_b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (iter) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check({name, " stall after flush"}, 64'(stall), 64'd0);
        check({name, " done after flush"}, 64'(done), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ndone += int'(done);
        end
        check({name, " no done pulse"}, 64'(ndone), 64'd0);
        check({name, " hi kept"}, hi, cur_hi);
        check({name, " lo kept"}, lo, cur_lo);
    endtask

    initial begin
        vecs[0]  = '{"multu_max_x2",  OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        vecs[1]  = '{"mult_m3_x7",    OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{"div_m7_2",      OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{"divu_100_7",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{"divu_by_zero",  OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{"div_min_m1",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{"div_by_zero",   OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{"mult_min_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8]  = '{"mult_m1_m1",    OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[9]  = '{"multu_max_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[10] = '{"div_7_m2",      OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[11] = '{"divu_max_16",   OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset done", 64'(done), 64'd0);
        check("reset dbz", 64'(dbz), 64'd0);
        check("reset stall", 64'(stall), 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz);
        end

        flush_at("flush_iter10", 10);
        flush_at("flush_last_edge", W - 1);

        // Back-to-back: start held high; operands change after the first start edge.
        begin
            exp_t e1, e2;
            int   n, ndone, t1, t2;
            e1.hi = 32'h0; e1.lo = 32'd12;  e1.dbz = 1'b0;
            e2.hi = 32'h0; e2.lo = 32'd100; e2.dbz = 1'b0;
            sb_q.push_back(e1);
            sb_q.push_back(e2);
            @(posedge clk); #1;
            start = 1'b1; op = OP_MULTU; data_a = 32'd3; data_b = 32'd4;
            n = 0; ndone = 0; t1 = -1; t2 = -1;
            while (ndone < 2 && n < 150) begin
                @(negedge clk);
                if (n == t1 + 1 && t1 >= 0) begin
                    check("b2b restart stall", 64'(stall), 64'd1);
                end
                if (done) begin
                    ndone++;
                    check("b2b stall in done", 64'(stall), 64'd0);
                    if (ndone == 1) begin
                        t1 = n;
                        pop_compare("b2b first");
                    end else begin
                        t2 = n;
                        start = 1'b0;
                        pop_compare("b2b second");
                    end
                end
                @(posedge clk); #1;
                if (n == 0) begin
                    data_a = 32'd10; data_b = 32'd10;
                end
                n++;
            end
            start = 1'b0;
            check("b2b both done", 64'(ndone), 64'd2);
            check("b2b first latency", 64'(t1), 64'(W + 1));
            check("b2b second latency", 64'(t2), 64'(2 * W + 3));
        end

        // Reset in the middle of BUSY.
        begin
            int ndone;
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1; op = OP_DIVU; data_a = 32'd100; data_b = 32'd7;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (5) begin
                @(posedge clk); #1;
            end
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            cur_hi = '0;
            cur_lo = '0;
            @(negedge clk);
            check("midreset hi", hi, 32'h0);
            check("midreset lo", lo, 32'h0);
            check("midreset stall", 64'(stall), 64'd0);
            ndone = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                ndone += int'(done);
            end
            check("midreset no done", 64'(ndone), 64'd0);
        end

        run_op("after_reset", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        check("scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
